// File: rtl/barrett_pkg.sv
// Shared types and constants for the Barrett reduction stage: FSM encoding,
// multiplier latency and the operand/product width helpers.
package barrett_pkg;

  typedef enum logic [3:0] {
    RST_FLUSH = 4'd0,
    IDLE      = 4'd1,
    MUL1      = 4'd2,
    WAIT1     = 4'd3,
    MUL2      = 4'd4,
    WAIT2     = 4'd5,
    SUB       = 4'd6,
    CORR1     = 4'd7,
    CORR2     = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam int MUL_LAT = 4;

  function automatic int w_plus1(input int w);
    return w + 1;
  endfunction

  function automatic int w_plus2(input int w);
    return w + 2;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 4;
  endfunction

endpackage

// File: rtl/karatsuba_mul.sv
// Four-stage pipelined Karatsuba multiplier (one level of splitting).
// Assumes A_WIDTH == B_WIDTH and even; o_done pulses MUL_LAT cycles after i_start.
module karatsuba_mul #(
  parameter int A_WIDTH = 34,
  parameter int B_WIDTH = 34
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [A_WIDTH-1:0]           i_a,
  input  logic [B_WIDTH-1:0]           i_b,
  output logic [A_WIDTH+B_WIDTH-1:0]   o_p,
  output logic                         o_done
);

  localparam int H  = A_WIDTH / 2;
  localparam int S  = H + 1;
  localparam int P2 = 2 * H;
  localparam int ZW = 2 * H + 2;
  localparam int PW = A_WIDTH + B_WIDTH;

  logic [H-1:0]  a1, a0, b1, b0;
  logic [S-1:0]  as, bs;
  logic [P2-1:0] z2_2, z0_2, z2_3, z0_3;
  logic [ZW-1:0] zm_2, z1_3;
  logic [PW-1:0] p_4;
  logic          v1, v2, v3, v4;

  // Only the valid chain is reset; data registers just follow it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
    end else begin
      v1 <= i_start;
      v2 <= v1;
      v3 <= v2;
      v4 <= v3;
    end
  end

  always_ff @(posedge i_clk) begin
    a1   <= i_a[A_WIDTH-1:H];
    a0   <= i_a[H-1:0];
    b1   <= i_b[B_WIDTH-1:H];
    b0   <= i_b[H-1:0];
    as   <= S'(i_a[A_WIDTH-1:H]) + S'(i_a[H-1:0]);
    bs   <= S'(i_b[B_WIDTH-1:H]) + S'(i_b[H-1:0]);
    z2_2 <= P2'(a1) * P2'(b1);
    z0_2 <= P2'(a0) * P2'(b0);
    zm_2 <= ZW'(as) * ZW'(bs);
    z1_3 <= zm_2 - ZW'(z2_2) - ZW'(z0_2);
    z2_3 <= z2_2;
    z0_3 <= z0_2;
    p_4  <= {z2_3, z0_3} + (PW'(z1_3) << H);
  end

  assign o_p    = p_4;
  assign o_done = v4;

endmodule

// File: rtl/barrett_reduce.sv
// Sequential Barrett reduction of a 2W-bit value mod Q on one shared multiplier.
// Define BARRETT_REDUCE_FAST_CORR_EN for a single-cycle three-way correction.
module barrett_reduce
  import barrett_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] Q     = 32'hFFFFFFFB,
  parameter logic [WIDTH:0]   MU    = 33'h1_00000005
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2*WIDTH-1:0]   i_x,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_r,
  output logic [3:0]           o_state
);

  localparam int W1 = w_plus1(WIDTH);
  localparam int W2 = w_plus2(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam logic [2:0] FLUSH_LAST = 3'(MUL_LAT - 1);

  // Handshake: i_start is accepted only in a cycle where o_busy is low; o_done
  // pulses for one cycle with o_r valid, and o_r holds until the next o_done.
  state_t            state, state_n;
  logic [2:0]        flush_cnt;
  logic [2*WIDTH-1:0] x;
  logic [W1-1:0]     q;
  logic [W2-1:0]     qq, r, corr_r;
  logic [WIDTH-1:0]  r_out;

  logic              mul_start, mul_done;
  logic [W2-1:0]     mul_a, mul_b;
  logic [PW-1:0]     mul_p;

  logic [W2-1:0]     q_ext;
  logic [W2:0]       d1;

  karatsuba_mul #(
    .A_WIDTH (W2),
    .B_WIDTH (W2)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (mul_start),
    .i_a     (mul_a),
    .i_b     (mul_b),
    .o_p     (mul_p),
    .o_done  (mul_done)
  );

  assign q_ext = W2'(Q);
  assign d1    = {1'b0, r} - {1'b0, q_ext};

  // r is kept W+2 bits wide so the whole [0, 3Q) range of the estimate fits.
`ifdef BARRETT_REDUCE_FAST_CORR_EN
  logic [W2:0] d2;
  assign d2 = {1'b0, r} - {1'b0, q_ext << 1};
  always_comb begin
    corr_r = r;
    if (!d2[W2])      corr_r = d2[W2-1:0];
    else if (!d1[W2]) corr_r = d1[W2-1:0];
  end
`else
  always_comb begin
    corr_r = r;
    if (!d1[W2]) corr_r = d1[W2-1:0];
  end
`endif

  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      RST_FLUSH: if (flush_cnt == FLUSH_LAST) state_n = IDLE;
      IDLE:      if (i_start) state_n = MUL1;
      MUL1: begin
        mul_start = 1'b1;
        mul_a     = W2'(x[2*WIDTH-1:WIDTH-1]);
        mul_b     = W2'(MU);
        state_n   = WAIT1;
      end
      WAIT1:     if (mul_done) state_n = MUL2;
      MUL2: begin
        mul_start = 1'b1;
        mul_a     = W2'(q);
        mul_b     = q_ext;
        state_n   = WAIT2;
      end
      WAIT2:     if (mul_done) state_n = SUB;
      SUB:       state_n = CORR1;
`ifdef BARRETT_REDUCE_FAST_CORR_EN
      CORR1:     state_n = DONE;
`else
      CORR1:     state_n = CORR2;
`endif
      CORR2:     state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = RST_FLUSH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RST_FLUSH;
      flush_cnt <= '0;
      x         <= '0;
      q         <= '0;
      qq        <= '0;
      r         <= '0;
      r_out     <= '0;
    end else begin
      state <= state_n;
      case (state)
        RST_FLUSH: flush_cnt <= flush_cnt + 3'd1;
        IDLE:      if (i_start) x <= i_x;
        WAIT1:     if (mul_done) q <= W1'(mul_p >> W1);
        WAIT2:     if (mul_done) qq <= W2'(mul_p);
        SUB:       r <= x[W2-1:0] - qq;
        CORR1: begin
          r <= corr_r;
`ifdef BARRETT_REDUCE_FAST_CORR_EN
          r_out <= corr_r[WIDTH-1:0];
`endif
        end
        CORR2: begin
          r     <= corr_r;
          r_out <= corr_r[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_r     = r_out;
  assign o_state = state;

endmodule

// File: tb/tb_barrett_reduce.sv
// Directed bench for barrett_reduce: timing, ignored starts, reset aborts and
// reference-mod comparison on random inputs.
module tb_barrett_reduce;
  import barrett_pkg::*;

`ifdef BARRETT_REDUCE_FAST_CORR_EN
  localparam int DONE_CYC = 13;
`else
  localparam int DONE_CYC = 14;
`endif
  localparam int PERIOD = DONE_CYC + 1;
  localparam logic [63:0] QV = 64'h0000_0000_FFFF_FFFB;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [63:0] i_x;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_r;
  logic [3:0]  o_state;

  int checks = 0;
  int errors = 0;

  barrett_reduce dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_x     (i_x),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_r     (o_r),
    .o_state (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start in cycle 0, then check busy/done every cycle and o_r on the done cycle.
  task automatic run(input logic [63:0] x, input logic [31:0] exp_r);
    i_start = 1'b1;
    i_x     = x;
    tick();
    i_start = 1'b0;
    i_x     = {$urandom, $urandom};
    for (int c = 1; c <= PERIOD; c++) begin
      check("busy", {63'd0, o_busy}, {63'd0, c <= DONE_CYC});
      check("done", {63'd0, o_done}, {63'd0, c == DONE_CYC});
      if (c == DONE_CYC) check("result", {32'd0, o_r}, {32'd0, exp_r});
      if (c < PERIOD) tick();
    end
  endtask

  task automatic flush_check();
    for (int k = 0; k < MUL_LAT; k++) begin
      check("flush_busy", {63'd0, o_busy}, 64'd1);
      check("flush_done", {63'd0, o_done}, 64'd0);
      tick();
    end
    check("flush_idle", {63'd0, o_busy}, 64'd0);
    check("idle_state", {60'd0, o_state}, {60'd0, IDLE});
  endtask

  initial begin
    logic [63:0] rx;
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_x     = '0;
    repeat (3) tick();
    check("rst_busy", {63'd0, o_busy}, 64'd1);
    check("rst_done", {63'd0, o_done}, 64'd0);
    check("rst_r", {32'd0, o_r}, 64'd0);
    check("rst_state", {60'd0, o_state}, {60'd0, RST_FLUSH});
    i_rst = 1'b0;
    flush_check();

    // Directed values with hand-computed residues
    run(64'd0, 32'd0);
    run(QV, 32'd0);
    run(QV + 64'd7, 32'd7);
    run(64'hFFFF_FFFF_FFFF_FFFF, 32'h18);
    run(64'hFFFF_FFF4_0000_0024, 32'd1);
    run(64'h0000_0001_0000_0000, 32'd5);
    run(64'h0000_0000_FFFF_FFFA, 32'hFFFF_FFFA);

    // Starts while busy are dropped; a start right after done is taken
    i_start = 1'b1;
    i_x     = 64'd5;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= PERIOD + DONE_CYC + 1; c++) begin
      check("ign_busy", {63'd0, o_busy},
            {63'd0, (c <= DONE_CYC) || (c > PERIOD && c <= PERIOD + DONE_CYC)});
      check("ign_done", {63'd0, o_done}, {63'd0, (c == DONE_CYC) || (c == PERIOD + DONE_CYC)});
      if (c == DONE_CYC) check("ign_r1", {32'd0, o_r}, 64'd5);
      if (c == PERIOD + DONE_CYC) check("ign_r2", {32'd0, o_r}, 64'd9);
      i_start = (c == 3) || (c == DONE_CYC) || (c == PERIOD);
      i_x     = i_start ? 64'd9 : 64'd0;
      if (c < PERIOD + DONE_CYC + 1) tick();
    end
    i_start = 1'b0;

    // Reset mid-multiply, with a start attempted during the flush
    i_start = 1'b1;
    i_x     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check("abort_busy", {63'd0, o_busy}, 64'd1);
      if (c == 7) i_rst = 1'b1;
      tick();
    end
    i_rst = 1'b0;
    for (int c = 8; c <= 30; c++) begin
      check("abort_busy2", {63'd0, o_busy}, {63'd0, c <= 11});
      check("abort_done", {63'd0, o_done}, 64'd0);
      check("abort_r", {32'd0, o_r}, 64'd0);
      i_start = (c == 9);
      i_x     = 64'd7;
      tick();
    end
    i_start = 1'b0;
    run(QV + 64'd3, 32'd3);

    // Reset landing on the DONE cycle
    i_start = 1'b1;
    i_x     = QV + 64'd7;
    tick();
    i_start = 1'b0;
    for (int c = 1; c < DONE_CYC; c++) tick();
    check("dr_done_pre", {63'd0, o_done}, 64'd1);
    check("dr_r_pre", {32'd0, o_r}, 64'd7);
    i_rst = 1'b1;
    tick();
    check("dr_done", {63'd0, o_done}, 64'd0);
    check("dr_r", {32'd0, o_r}, 64'd0);
    check("dr_busy", {63'd0, o_busy}, 64'd1);
    i_rst = 1'b0;
    flush_check();
    run(64'h0000_0001_0000_0000, 32'd5);

    // Random values against a reference modulo
    for (int n = 0; n < 1000; n++) begin
      rx = {$urandom, $urandom};
      if (n < 4) rx = 64'hFFFF_FFFF_0000_0000 | 64'(n);
      run(rx, 32'(rx % QV));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
